// File: rtl/user_obi_arbiter.sv
// Round-robin arbiter merging NumReq OBI managers onto one shared OBI port, with in-order response routing.
// Optional macro USER_OBI_ARB_PRIO0_EN: requester 0 wins every unlocked arbitration.
module user_obi_arbiter #(
    parameter int unsigned NumReq    = 3,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_i,
    output logic [NumReq-1:0]                    gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 mgr_req_o,
    output logic [AddrWidth-1:0]                 mgr_addr_o,
    output logic                                 mgr_we_o,
    output logic [DataWidth/8-1:0]               mgr_be_o,
    output logic [DataWidth-1:0]                 mgr_wdata_o,
    input  logic                                 mgr_gnt_i,
    input  logic                                 mgr_rvalid_i,
    input  logic [DataWidth-1:0]                 mgr_rdata_i,
    input  logic                                 mgr_err_i,
    output logic                                 spurious_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] cand_idx;
    int unsigned     cand;
    logic            found;

    logic [IdxW-1:0] id_fifo_q [MaxTrans];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            full;
    logic            empty;
    logic            hs;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Winner selection: held requester while locked, otherwise first requester at/after rr_ptr
    always_comb begin
        sel      = rr_ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
`ifdef USER_OBI_ARB_PRIO0_EN
            if (req_i[0]) begin
                sel   = '0;
                found = 1'b1;
            end
`endif
            for (int unsigned i = 0; i < NumReq; i++) begin
                cand = 32'(rr_ptr_q) + i;
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                cand_idx = IdxW'(cand);
`ifdef USER_OBI_ARB_PRIO0_EN
                if (!found && req_i[cand_idx] && (cand_idx != '0)) begin
`else
                if (!found && req_i[cand_idx]) begin
`endif
                    sel   = cand_idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign full        = (cnt_q == CntW'(MaxTrans));
    assign empty       = (cnt_q == '0);
    assign mgr_req_o   = ~rst_i & req_i[sel] & ~full;
    assign hs          = mgr_req_o & mgr_gnt_i;
    assign pop         = ~rst_i & mgr_rvalid_i & ~empty;
    assign mgr_addr_o  = addr_i[sel];
    assign mgr_we_o    = we_i[sel];
    assign mgr_be_o    = be_i[sel];
    assign mgr_wdata_o = wdata_i[sel];
    assign rdata_o     = mgr_rdata_i;
    assign err_o       = mgr_err_i;

    // One-hot grant and response routing
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            rvalid_o[id_fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            spurious_o <= 1'b0;
        end else begin
            lock_q     <= mgr_req_o & ~mgr_gnt_i;
            lock_idx_q <= sel;
            if (hs) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                rr_ptr_q <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CntW'(hs) - CntW'(pop);
            if (mgr_rvalid_i && empty) begin
                spurious_o <= 1'b1;
            end
        end
    end

    // ID storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk_i) begin
        if (!rst_i && hs) begin
            id_fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Bench for user_obi_arbiter: directed vector table followed by randomized traffic against a queue-based model.
module tb_user_obi_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_i;
    logic [N-1:0]           req_i;
    logic [N-1:0]           gnt_o;
    logic [N-1:0][AW-1:0]   addr_i;
    logic [N-1:0]           we_i;
    logic [N-1:0][DW/8-1:0] be_i;
    logic [N-1:0][DW-1:0]   wdata_i;
    logic [N-1:0]           rvalid_o;
    logic [DW-1:0]          rdata_o;
    logic                   err_o;
    logic                   mgr_req_o;
    logic [AW-1:0]          mgr_addr_o;
    logic                   mgr_we_o;
    logic [DW/8-1:0]        mgr_be_o;
    logic [DW-1:0]          mgr_wdata_o;
    logic                   mgr_gnt_i;
    logic                   mgr_rvalid_i;
    logic [DW-1:0]          mgr_rdata_i;
    logic                   mgr_err_i;
    logic                   spurious_o;

    user_obi_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o), .mgr_we_o(mgr_we_o),
        .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o), .mgr_gnt_i(mgr_gnt_i),
        .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i),
        .spurious_o(spurious_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [1:0]  e_sel;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic        e_spur;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [2:0] req, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic e_req,
                                input logic [1:0] e_sel, input logic [2:0] e_gnt,
                                input logic [2:0] e_rv, input logic e_spur);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_sel = e_sel; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_spur = e_spur;
        vecs.push_back(v);
    endfunction

    // Reference model state
    int q[$];
    int rr     = 0;
    int locked = -1;
    bit spur   = 1'b0;

    initial begin
        rst_i = 1'b1; req_i = '0; mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b0;
        mgr_rdata_i = '0; mgr_err_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            addr_i[k]  = 32'h1000_0000 + 32'(k) * 32'h100;
            we_i[k]    = k[0];
            be_i[k]    = 4'(k + 5);
            wdata_i[k] = 32'hD000_0000 + 32'(k);
        end

        // reset
        add(1, 3'b111, 1, 1, 0, 0, 0, 3'b000, 3'b000, 0);
`ifndef USER_OBI_ARB_PRIO0_EN
        // fairness 0,1,2,0,1,2 with one response per cycle
        add(0, 3'b111, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        add(0, 3'b111, 1, 1, 1, 1, 1, 3'b010, 3'b001, 0);
        add(0, 3'b111, 1, 1, 2, 1, 2, 3'b100, 3'b010, 0);
        add(0, 3'b111, 1, 1, 3, 1, 0, 3'b001, 3'b100, 0);
        add(0, 3'b111, 1, 1, 4, 1, 1, 3'b010, 3'b001, 0);
        add(0, 3'b111, 1, 1, 5, 1, 2, 3'b100, 3'b010, 0);
        add(0, 3'b000, 0, 1, 6, 0, 0, 3'b000, 3'b100, 0);
`else
        // requester 0 always wins when unlocked
        add(0, 3'b111, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        for (int k = 1; k < 6; k++) add(0, 3'b111, 1, 1, 32'(k), 1, 0, 3'b001, 3'b001, 0);
        add(0, 3'b000, 0, 1, 6, 0, 0, 3'b000, 3'b001, 0);
`endif
        add(1, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        // lock: requester 1 held while requester 0 arrives
        add(0, 3'b010, 0, 0, 0, 1, 1, 3'b000, 3'b000, 0);
        add(0, 3'b011, 0, 0, 0, 1, 1, 3'b000, 3'b000, 0);
        add(0, 3'b011, 0, 0, 0, 1, 1, 3'b000, 3'b000, 0);
        add(0, 3'b011, 1, 0, 0, 1, 1, 3'b010, 3'b000, 0);
        add(0, 3'b011, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        add(0, 3'b000, 0, 1, 32'h11, 0, 0, 3'b000, 3'b010, 0);
        add(0, 3'b000, 0, 1, 32'h12, 0, 0, 3'b000, 3'b001, 0);
        add(1, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        // response routing 2,0,1
        add(0, 3'b100, 1, 0, 0, 1, 2, 3'b100, 3'b000, 0);
        add(0, 3'b001, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        add(0, 3'b010, 1, 0, 0, 1, 1, 3'b010, 3'b000, 0);
        add(0, 3'b000, 0, 1, 32'hA, 0, 0, 3'b000, 3'b100, 0);
        add(0, 3'b000, 0, 1, 32'hB, 0, 0, 3'b000, 3'b001, 0);
        add(0, 3'b000, 0, 1, 32'hC, 0, 0, 3'b000, 3'b010, 0);
        add(1, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        // FIFO-full back-pressure
        for (int k = 0; k < 4; k++) add(0, 3'b001, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        add(0, 3'b001, 1, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b001, 1, 1, 32'h21, 0, 0, 3'b000, 3'b001, 0);
        add(0, 3'b001, 1, 0, 0, 1, 0, 3'b001, 3'b000, 0);
        add(0, 3'b001, 1, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 3'b000, 0, 1, 32'h30 + 32'(k), 0, 0, 3'b000, 3'b001, 0);
        // spurious response, then reset discarding an outstanding ID
        add(0, 3'b000, 0, 1, 32'h40, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
        add(0, 3'b010, 1, 0, 0, 1, 1, 3'b010, 3'b000, 1);
        add(1, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 1, 32'h50, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
        add(1, 3'b111, 1, 1, 0, 0, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);

        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_i = vecs[i].rst; req_i = vecs[i].req; mgr_gnt_i = vecs[i].gnt;
            mgr_rvalid_i = vecs[i].rv; mgr_rdata_i = vecs[i].rdata;
            #1;
            chk($sformatf("row%0d.mgr_req", i), 64'(mgr_req_o), 64'(vecs[i].e_req));
            chk($sformatf("row%0d.gnt", i), 64'(gnt_o), 64'(vecs[i].e_gnt));
            chk($sformatf("row%0d.rvalid", i), 64'(rvalid_o), 64'(vecs[i].e_rv));
            chk($sformatf("row%0d.spurious", i), 64'(spurious_o), 64'(vecs[i].e_spur));
            if (vecs[i].e_req) begin
                chk($sformatf("row%0d.addr", i), 64'(mgr_addr_o), 64'(addr_i[vecs[i].e_sel]));
                chk($sformatf("row%0d.wdata", i), 64'(mgr_wdata_o), 64'(wdata_i[vecs[i].e_sel]));
            end
            if (vecs[i].e_rv != 3'b000) begin
                chk($sformatf("row%0d.rdata", i), 64'(rdata_o), 64'(vecs[i].rdata));
            end
        end

        // randomized traffic vs. model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int   sel;
            bit   found;
            bit   e_req;
            bit   had;
            logic [2:0] e_gnt;
            logic [2:0] e_rv;
            @(negedge clk);
            rst_i        = ($urandom_range(0, 99) == 0);
            req_i        = 3'($urandom);
            mgr_gnt_i    = ($urandom_range(0, 9) < 7);
            mgr_rvalid_i = ($urandom_range(0, 9) < 4);
            mgr_rdata_i  = $urandom;
            mgr_err_i    = 1'($urandom);
            for (int k = 0; k < N; k++) begin
                addr_i[k]  = $urandom;
                we_i[k]    = 1'($urandom);
                be_i[k]    = 4'($urandom);
                wdata_i[k] = $urandom;
            end
            #1;
            sel = 0;
            found = 1'b0;
            if (locked >= 0) begin
                sel = locked;
                found = 1'b1;
            end else begin
`ifdef USER_OBI_ARB_PRIO0_EN
                if (req_i[0]) begin
                    sel = 0;
                    found = 1'b1;
                end
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
                    if (!found && idx != 0 && req_i[idx]) begin
                        sel = idx;
                        found = 1'b1;
                    end
                end
`else
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
                    if (!found && req_i[idx]) begin
                        sel = idx;
                        found = 1'b1;
                    end
                end
`endif
            end
            e_req = !rst_i && found && req_i[sel] && (q.size() < MT);
            e_gnt = (e_req && mgr_gnt_i) ? 3'(1 << sel) : 3'b000;
            had   = (q.size() > 0);
            e_rv  = (!rst_i && mgr_rvalid_i && had) ? 3'(1 << q[0]) : 3'b000;

            chk($sformatf("rnd%0d.mgr_req", cyc), 64'(mgr_req_o), 64'(e_req));
            chk($sformatf("rnd%0d.gnt", cyc), 64'(gnt_o), 64'(e_gnt));
            chk($sformatf("rnd%0d.rvalid", cyc), 64'(rvalid_o), 64'(e_rv));
            chk($sformatf("rnd%0d.spurious", cyc), 64'(spurious_o), 64'(spur));
            if (e_req) begin
                chk($sformatf("rnd%0d.addr", cyc), 64'(mgr_addr_o), 64'(addr_i[sel]));
                chk($sformatf("rnd%0d.we", cyc), 64'(mgr_we_o), 64'(we_i[sel]));
                chk($sformatf("rnd%0d.be", cyc), 64'(mgr_be_o), 64'(be_i[sel]));
                chk($sformatf("rnd%0d.wdata", cyc), 64'(mgr_wdata_o), 64'(wdata_i[sel]));
            end
            if (e_rv != 3'b000) begin
                chk($sformatf("rnd%0d.rdata", cyc), 64'(rdata_o), 64'(mgr_rdata_i));
                chk($sformatf("rnd%0d.err", cyc), 64'(err_o), 64'(mgr_err_i));
            end

            if (rst_i) begin
                q.delete();
                rr     = 0;
                locked = -1;
                spur   = 1'b0;
            end else begin
                if (mgr_rvalid_i && had) void'(q.pop_front());
                else if (mgr_rvalid_i) spur = 1'b1;
                if (e_req && mgr_gnt_i) begin
                    q.push_back(sel);
                    rr = (sel + 1) % N;
                end
                locked = (e_req && !mgr_gnt_i) ? sel : -1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/user_obi_arbiter.md
USER_OBI_ARBITER -- requirements
Module: user_obi_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 3, number of OBI manager requesters (iDMA read, iDMA write, PJON).
REQ-002 SHALL have parameter AddrWidth, default 32, OBI address width.
REQ-003 SHALL have parameter DataWidth, default 32, OBI data width.
REQ-004 SHALL have parameter MaxTrans, default 4, maximum outstanding transactions on the shared port.
REQ-005 SHALL have the port clk_i: input, 1 bit, the single clock; all state is on its rising edge.
REQ-006 SHALL have the port rst_i: input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have the ports req_i / gnt_o: input / output, NumReq bits, per-requester OBI request and grant.
REQ-008 SHALL have the ports addr_i, we_i, be_i, wdata_i: inputs, NumReq x (AddrWidth, 1, DataWidth/8, DataWidth), per-requester A-channel fields.
REQ-009 SHALL have the port rvalid_o: output, NumReq bits, per-requester response valid.
REQ-010 SHALL have the ports rdata_o / err_o: outputs, DataWidth / 1 bit, response data and error, broadcast to all requesters.
REQ-011 SHALL have the ports mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o: outputs, shared OBI A-channel.
REQ-012 SHALL have the port mgr_gnt_i: input, 1 bit, shared grant.
REQ-013 SHALL have the ports mgr_rvalid_i, mgr_rdata_i, mgr_err_i: inputs, shared R-channel.
REQ-014 SHALL have the port spurious_o: output, 1 bit, sticky flag for an rvalid arriving with no outstanding transaction.

Function
REQ-015 SHALL drive mgr_req_o combinationally from the selected requester's req_i, gated low while the ID FIFO holds MaxTrans entries.
REQ-016 SHALL mux the mgr A-channel fields from the selected requester; gnt_o[sel] = mgr_gnt_i & mgr_req_o; all other gnt_o bits SHALL be 0.
REQ-017 SHALL select by round robin: the first requesting index at or after rr_ptr, wrapping from NumReq-1 to 0.
REQ-018 SHALL update rr_ptr to (winner+1) mod NumReq on every mgr handshake (mgr_req_o & mgr_gnt_i), and only then.
REQ-019 SHALL lock the selection while mgr_req_o is high and mgr_gnt_i is low; a higher-ranked new request SHALL NOT preempt the locked requester (OBI A-channel stability).
REQ-020 SHALL release the lock on handshake; a new selection SHALL be available in the next cycle (one transfer per cycle maximum).
REQ-021 SHALL push the winner index into an ID FIFO of depth MaxTrans on each handshake.
REQ-022 SHALL pop the ID FIFO on mgr_rvalid_i, asserting rvalid_o[head] in the same cycle; rdata_o = mgr_rdata_i and err_o = mgr_err_i, both combinational.
REQ-023 SHALL allow push and pop in the same cycle when not full; when full, a same-cycle pop SHALL NOT unblock the request until the next cycle.
REQ-024 SHALL ignore mgr_rvalid_i while the FIFO is empty, set spurious_o, and assert no rvalid_o bit.
REQ-025 SHALL keep spurious_o set until reset.
REQ-026 SHALL return responses in grant order regardless of requester index.

Reset
REQ-027 SHALL, on rst_i high at a clock edge, clear: FIFO (empty), rr_ptr = 0, lock, and spurious_o.
REQ-028 SHALL hold mgr_req_o, all gnt_o and all rvalid_o at 0 while rst_i is high.
REQ-029 SHALL discard outstanding IDs when reset is applied mid-operation; later responses SHALL count as spurious.

Configuration
REQ-030 SHALL honour the macro USER_OBI_ARB_PRIO0_EN: when defined, requester 0 SHALL win any unlocked arbitration, and round robin SHALL apply among the rest.
REQ-031 SHALL, without the USER_OBI_ARB_PRIO0_EN macro, apply pure round robin over all NumReq requesters.
REQ-032 SHALL apply the lock in both configurations.

Verification
REQ-033 SHALL verify round-robin fairness: req_i=3'b111 and mgr_gnt_i=1 held for 6 cycles -> grant order 0,1,2,0,1,2.
REQ-034 SHALL verify the lock: req_i=3'b010 with gnt low for 3 cycles, req_i[0] rising in cycle 2 -> mgr_addr_o stays addr_i[1] until the grant, then requester 0 is served next.
REQ-035 SHALL verify FIFO-full back-pressure: MaxTrans=4 with 4 grants and no rvalid -> mgr_req_o=0 with req_i high; one rvalid -> request re-asserted the next cycle.
REQ-036 SHALL verify response routing: grants to requesters 2,0,1 with rdata 0xA,0xB,0xC -> rvalid_o pulses 3'b100,3'b001,3'b010 carrying matching data.
REQ-037 SHALL verify spurious-response handling: rvalid with the FIFO empty -> no rvalid_o bit, spurious_o=1 until rst_i.
REQ-038 SHALL verify requester-0 priority: with USER_OBI_ARB_PRIO0_EN defined and req_i=3'b111 held for 3 cycles -> grants 0,0,0; with it undefined -> grants 0,1,2.
